// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Purpose:
//   Free-running VGA raster timing generator. A horizontal pixel counter and a
//   vertical line counter are driven straight onto DrawX/DrawY. Sync, blank
//   and the start pulses are registered from the *next* counter values, so
//   every output in a given cycle describes the same (DrawX, DrawY).
//
// Parameters:
//   H_VISIBLE, H_FP, H_SYNC, H_BP : horizontal timing in pixels
//   V_VISIBLE, V_FP, V_SYNC, V_BP : vertical timing in lines
//   H_TOTAL and V_TOTAL must each be at most 1024.
//
// Ports:
//   vga_clk     in   pixel clock, rising edge, the only clock
//   reset_n     in   asynchronous active-low reset
//   DrawX       out  [9:0] current pixel column
//   DrawY       out  [9:0] current pixel line
//   hs          out  horizontal sync, active-low
//   vs          out  vertical sync, active-low
//   blank       out  display enable, 1 = visible pixel
//   frame_start out  one-cycle pulse at pixel (0,0)
//   line_start  out  one-cycle pulse whenever DrawX = 0
//   frame_count out  [7:0] frames started since reset, wraps 255 -> 0
//                    (present only when VGA_FRAME_COUNT_EN is defined)
//
// Build option:
//   VGA_FRAME_COUNT_EN - adds the frame_count port and its register.
// ---------------------------------------------------------------------------
module vga_timing_gen #(
   parameter int H_VISIBLE = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33
) (
   input  logic       vga_clk,
   input  logic       reset_n,
   output logic [9:0] DrawX,
   output logic [9:0] DrawY,
   output logic       hs,
   output logic       vs,
   output logic       blank,
   output logic       frame_start,
`ifdef VGA_FRAME_COUNT_EN
   output logic [7:0] frame_count,
`endif
   output logic       line_start
);

   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

   generate
      if (H_TOTAL > 1024 || V_TOTAL > 1024 || H_TOTAL < 1 || V_TOTAL < 1) begin : g_bad_timing
         $error("vga_timing_gen: H_TOTAL and V_TOTAL must be in 1..1024");
      end
   endgenerate

   localparam logic [9:0] H_MAX = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_MAX = 10'(V_TOTAL - 1);

   // Region bounds are held at 11 bits: an upper bound may legitimately equal
   // 1024 when the following porch is zero and the total is at the limit.
   localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
   localparam logic [10:0] H_SYNC_BEG = 11'(H_VISIBLE + H_FP);
   localparam logic [10:0] H_SYNC_END = 11'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
   localparam logic [10:0] V_SYNC_BEG = 11'(V_VISIBLE + V_FP);
   localparam logic [10:0] V_SYNC_END = 11'(V_VISIBLE + V_FP + V_SYNC);

   logic [9:0]  r_h_cnt;
   logic [9:0]  r_v_cnt;
   logic        r_hs;
   logic        r_vs;
   logic        r_blank;
   logic        r_frame_start;
   logic        r_line_start;

   logic        w_h_at_max;
   logic        w_v_at_max;
   logic [9:0]  w_h_nxt;
   logic [9:0]  w_v_nxt;
   logic [10:0] w_h_nxt_ext;
   logic [10:0] w_v_nxt_ext;
   logic        w_hs_nxt;
   logic        w_vs_nxt;
   logic        w_blank_nxt;
   logic        w_frame_start_nxt;
   logic        w_line_start_nxt;

   // Explicit compare-and-wrap; the +1 is never evaluated at 1023 because a
   // counter at its maximum takes the wrap branch instead.
   assign w_h_at_max = (r_h_cnt == H_MAX);
   assign w_v_at_max = (r_v_cnt == V_MAX);

   always_comb begin
      w_h_nxt = r_h_cnt;
      w_v_nxt = r_v_cnt;
      if (w_h_at_max) begin
         w_h_nxt = 10'd0;
         if (w_v_at_max) begin
            w_v_nxt = 10'd0;
         end else begin
            w_v_nxt = r_v_cnt + 10'd1;
         end
      end else begin
         w_h_nxt = r_h_cnt + 10'd1;
      end
   end

   assign w_h_nxt_ext = {1'b0, w_h_nxt};
   assign w_v_nxt_ext = {1'b0, w_v_nxt};

   // Decode from the next position so the registered flags line up with the
   // counter registers that are loaded on the same edge.
   assign w_blank_nxt       = (w_h_nxt_ext < H_VIS_END) && (w_v_nxt_ext < V_VIS_END);
   assign w_hs_nxt          = !((w_h_nxt_ext >= H_SYNC_BEG) && (w_h_nxt_ext < H_SYNC_END));
   assign w_vs_nxt          = !((w_v_nxt_ext >= V_SYNC_BEG) && (w_v_nxt_ext < V_SYNC_END));
   assign w_line_start_nxt  = (w_h_nxt == 10'd0);
   assign w_frame_start_nxt = (w_h_nxt == 10'd0) && (w_v_nxt == 10'd0);

   // Reset parks the counters on the last pixel of the frame so the first
   // edge after release wraps naturally to (0,0) with both start pulses.
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_h_cnt       <= H_MAX;
         r_v_cnt       <= V_MAX;
         r_hs          <= 1'b1;
         r_vs          <= 1'b1;
         r_blank       <= 1'b0;
         r_frame_start <= 1'b0;
         r_line_start  <= 1'b0;
      end else begin
         r_h_cnt       <= w_h_nxt;
         r_v_cnt       <= w_v_nxt;
         r_hs          <= w_hs_nxt;
         r_vs          <= w_vs_nxt;
         r_blank       <= w_blank_nxt;
         r_frame_start <= w_frame_start_nxt;
         r_line_start  <= w_line_start_nxt;
      end
   end

   assign DrawX       = r_h_cnt;
   assign DrawY       = r_v_cnt;
   assign hs          = r_hs;
   assign vs          = r_vs;
   assign blank       = r_blank;
   assign frame_start = r_frame_start;
   assign line_start  = r_line_start;

`ifdef VGA_FRAME_COUNT_EN
   logic [7:0] r_frame_cnt;

   // Counts on the same edge that raises frame_start, so the value seen
   // during the first frame after reset is 1.
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_frame_cnt <= 8'd0;
      end else if (w_frame_start_nxt) begin
         if (r_frame_cnt == 8'd255) begin
            r_frame_cnt <= 8'd0;
         end else begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
         end
      end
   end

   assign frame_count = r_frame_cnt;
`endif

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640: active pixels per line.
REQ-002 SHALL have parameter H_FP, default 16: horizontal front porch, in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96: hsync width, in pixels.
REQ-004 SHALL have parameter H_BP, default 48: horizontal back porch, in pixels.
REQ-005 SHALL have parameter V_VISIBLE, default 480: active lines per frame.
REQ-006 SHALL have parameters V_FP, V_SYNC and V_BP, defaults 10, 2 and 33: vertical porches and sync width, in lines.
REQ-007 SHALL have port vga_clk, input, 1: pixel clock, rising edge; the only clock.
REQ-008 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-009 SHALL have port DrawX, output, 10: current pixel column.
REQ-010 SHALL have port DrawY, output, 10: current pixel line.
REQ-011 SHALL have port hs, output, 1: horizontal sync, active-low.
REQ-012 SHALL have port vs, output, 1: vertical sync, active-low.
REQ-013 SHALL have port blank, output, 1: display enable; 1 = visible pixel, 0 = porch/sync.
REQ-014 SHALL have port frame_start, output, 1: one-cycle pulse at pixel (0,0).
REQ-015 SHALL have port line_start, output, 1: one-cycle pulse whenever DrawX = 0.

Function
REQ-016 SHALL define H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP and V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP; both SHALL be at most 1024. Defaults give 800 and 525.
REQ-017 SHALL increment the horizontal counter by 1 on every vga_clk edge and wrap it from H_TOTAL-1 to 0.
REQ-018 SHALL increment the vertical counter only on a horizontal wrap, and wrap it from V_TOTAL-1 to 0 when both counters are at their maxima.
REQ-019 SHALL drive DrawX and DrawY directly from the counter registers.
REQ-020 SHALL register hs, vs, blank, frame_start and line_start, and compute them from the next counter values, so every output in a cycle describes the same (DrawX, DrawY).
REQ-021 SHALL drive blank = 1 if and only if DrawX < H_VISIBLE and DrawY < V_VISIBLE.
REQ-022 SHALL drive hs = 0 if and only if H_VISIBLE+H_FP <= DrawX < H_VISIBLE+H_FP+H_SYNC (656..751 at defaults).
REQ-023 SHALL drive vs = 0 if and only if V_VISIBLE+V_FP <= DrawY < V_VISIBLE+V_FP+V_SYNC (490..491 at defaults), for the whole line including porches.
REQ-024 SHALL assert frame_start if and only if DrawX = 0 and DrawY = 0, so the pulses are H_TOTAL*V_TOTAL cycles apart (420000 at defaults).
REQ-025 SHALL have zero latency from the counter state to every output; there is no handshake and the block free-runs.
REQ-026 SHALL perform all counter arithmetic at 10 bits with explicit compare-and-wrap, and SHALL NOT rely on modular overflow.

Reset
REQ-027 SHALL, while reset_n = 0, hold DrawX = H_TOTAL-1, DrawY = V_TOTAL-1 (799, 524), hs = 1, vs = 1, blank = 0, frame_start = 0 and line_start = 0.
REQ-028 SHALL, on the first vga_clk edge after reset_n rises, present DrawX = 0, DrawY = 0, blank = 1, frame_start = 1 and line_start = 1.
REQ-029 SHALL, when reset_n is asserted mid-frame, force the reset values of REQ-027 immediately without waiting for a clock edge, and restart at (0,0) after release.

Configuration
REQ-030 SHALL, when VGA_FRAME_COUNT_EN is defined, add output port frame_count, 8 bits, reset to 0, which increments on every edge where frame_start is asserted and wraps from 255 to 0.
REQ-031 SHALL, when VGA_FRAME_COUNT_EN is undefined, omit the frame_count port and its register entirely, with all other behaviour identical.

Verification
REQ-032 SHALL cover: release reset_n -> first edge DrawX=0, DrawY=0, blank=1, frame_start=1; next edge DrawX=1, frame_start=0.
REQ-033 SHALL cover: run one line -> hs=0 for exactly 96 consecutive cycles, DrawX 656..751; blank falls as DrawX goes 639->640; DrawX wraps 799->0 with line_start=1 and DrawY+1.
REQ-034 SHALL cover: run a full frame -> vs=0 for exactly 1600 cycles (DrawY 490..491); blank=0 for all DrawY >= 480; the next frame_start comes 420000 cycles after the first.
REQ-035 SHALL cover: assert reset_n=0 asynchronously at (300,200) -> outputs take the REQ-027 values within the same cycle; after release, sequence restarts at (0,0) with frame_start=1.
REQ-036 SHALL cover: with VGA_FRAME_COUNT_EN defined, run 257 frames -> frame_count goes 1, 2, ..., 255, 0, 1.
REQ-037 SHALL cover: with non-default parameters H=8/1/2/1, V=4/1/1/1 -> H_TOTAL=12, V_TOTAL=7, hs low at DrawX 9..10, frame period 84 cycles.
